// File: rtl/uart_tx_frame_feeder.sv
// Byte FIFO feeding a UART frame serializer: builds start/data/parity/stop frames
// and handshakes each one with the serializer's baud-domain Active/Done flags.
module uart_tx_frame_feeder #(
    parameter int FRAME_BITS  = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          Clk,
    input  logic                          ResetN,
    input  logic [7:0]                    DataIn,
    input  logic                          DataValid,
    output logic                          DataReady,
    input  logic [1:0]                    ParityType,
    input  logic                          StopBits,
    input  logic                          DataLength,
    input  logic                          TxActive,
    input  logic                          TxDone,
    output logic                          Send,
    output logic [FRAME_BITS-1:0]         FrameOut,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_ACT  = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   ready_en;
    logic [SYNC_STAGES-1:0] act_sync, done_sync;
    logic                   act_s, done_s;
    logic [2:0]             state, state_nx;
    logic                   send_q;
    logic [FRAME_BITS-1:0]  frame_q, frame_nx;
    logic [7:0]             head;
    logic                   push, pop;
    logic                   par_x, par_bit, has_par;

    // Stop bits and idle padding are both 1, so StopBits never changes the frame bits.
    logic stop_bits_unused;
    assign stop_bits_unused = StopBits;

    assign DataReady = ready_en && (count < CW'(FIFO_DEPTH));
    assign push      = DataValid && DataReady;
    assign pop       = (state == LOAD);
    assign head      = mem[rd_ptr];
    assign act_s     = act_sync[SYNC_STAGES-1];
    assign done_s    = done_sync[SYNC_STAGES-1];

    assign Send      = send_q;
    assign FrameOut  = frame_q;
    assign FifoCount = count;
    assign Busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ready_en  <= 1'b0;
            act_sync  <= '0;
            done_sync <= '0;
        end else begin
            ready_en  <= 1'b1;
            act_sync  <= SYNC_STAGES'({act_sync, TxActive});
            done_sync <= SYNC_STAGES'({done_sync, TxDone});
        end
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr] <= DataIn;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame layout assumes FRAME_BITS >= 12 (start + 8 data + parity + 2 stop).
    always_comb begin
        int ndata;
        ndata    = DataLength ? 8 : 7;
        par_x    = DataLength ? ^head : ^head[6:0];
        has_par  = (ParityType == 2'b01) || (ParityType == 2'b10);
        par_bit  = (ParityType == 2'b01) ? ~par_x : par_x;
        frame_nx = '1;
        frame_nx[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < ndata) frame_nx[i+1] = head[i];
        end
        for (int b = 8; b <= 9; b++) begin
            if (has_par && (b == ndata + 1)) frame_nx[b] = par_bit;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (count != '0) state_nx = LOAD;
            LOAD:      state_nx = WAIT_ACT;
            // DoneFlag idles high, so it only counts once Active has been seen.
            WAIT_ACT:  if (act_s) state_nx = WAIT_DONE;
            WAIT_DONE: if (done_s && !act_s) state_nx = GAP;
            GAP:       state_nx = (count != '0) ? LOAD : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            send_q  <= 1'b0;
            frame_q <= '1;
        end else begin
            state  <= state_nx;
            send_q <= (state_nx == LOAD) || (state_nx == WAIT_ACT) || (state_nx == WAIT_DONE);
            if (state == LOAD) frame_q <= frame_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_feeder.sv
// Directed bench for uart_tx_frame_feeder: frame table plus FIFO-fill,
// back-to-back, mid-frame config change and mid-frame reset sequences.
module tb_uart_tx_frame_feeder;

    localparam int FB   = 12;
    localparam int SYNC = 2;

    logic          Clk, ResetN;
    logic [7:0]    DataIn;
    logic          DataValid, DataReady;
    logic [1:0]    ParityType;
    logic          StopBits, DataLength;
    logic          TxActive, TxDone;
    logic          Send;
    logic [FB-1:0] FrameOut;
    logic [2:0]    FifoCount;
    logic          Busy;

    uart_tx_frame_feeder #(.FRAME_BITS(FB), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut (
        .Clk(Clk), .ResetN(ResetN), .DataIn(DataIn), .DataValid(DataValid),
        .DataReady(DataReady), .ParityType(ParityType), .StopBits(StopBits),
        .DataLength(DataLength), .TxActive(TxActive), .TxDone(TxDone),
        .Send(Send), .FrameOut(FrameOut), .FifoCount(FifoCount), .Busy(Busy)
    );

    typedef struct {
        logic [7:0]    data;
        logic          len;
        logic [1:0]    par;
        logic          stop;
        logic [FB-1:0] frame;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bit ok = 1'b0;
        DataIn    = d;
        DataValid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = DataReady;
            tick();
        end
        DataValid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_send();
        int n = 0;
        while (!Send && n < 20) begin
            tick();
            n++;
        end
        if (!Send) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Serializer finishing: Active low, Done high; returns cycles until Send falls.
    task automatic finish_frame(output int n);
        TxActive = 1'b0;
        TxDone   = 1'b1;
        n = 0;
        while (Send && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic begin_frame();
        TxActive = 1'b1;
        TxDone   = 1'b0;
        repeat (4) tick();
    endtask

    logic [FB-1:0] b2b_exp[5];
    int            n, acc, cyc;
    bit            seen;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 2'b10, 1'b1, 12'hD4A};
        vecs[1] = '{8'h41, 1'b0, 2'b01, 1'b0, 12'hF82};
        vecs[2] = '{8'h00, 1'b1, 2'b00, 1'b0, 12'hE00};
        vecs[3] = '{8'hFF, 1'b1, 2'b01, 1'b1, 12'hFFE};
        vecs[4] = '{8'h80, 1'b0, 2'b10, 1'b0, 12'hE00};
        vecs[5] = '{8'h3C, 1'b1, 2'b11, 1'b1, 12'hE78};
        vecs[6] = '{8'h55, 1'b0, 2'b10, 1'b1, 12'hEAA};
        b2b_exp = '{12'hE22, 12'hC24, 12'hE26, 12'hC28, 12'hE2A};

        ResetN = 1'b0; DataIn = '0; DataValid = 1'b0;
        ParityType = 2'b00; StopBits = 1'b0; DataLength = 1'b1;
        TxActive = 1'b0; TxDone = 1'b1;
        repeat (3) tick();
        chk("rst_ready", DataReady, 0);
        chk("rst_send", Send, 0);
        chk("rst_frame", FrameOut, 12'hFFF);
        chk("rst_count", FifoCount, 0);
        chk("rst_busy", Busy, 0);
        ResetN = 1'b1;
        #1 chk("ready_before_clk", DataReady, 0);
        tick();
        chk("ready_after_clk", DataReady, 1);

        for (int v = 0; v < 7; v++) begin
            DataLength = vecs[v].len;
            ParityType = vecs[v].par;
            StopBits   = vecs[v].stop;
            push_byte(vecs[v].data);
            chk("lat_send_lo", Send, 0);
            chk("lat_count1", FifoCount, 1);
            chk("lat_busy", Busy, 1);
            tick();
            chk("lat_send_hi", Send, 1);
            tick();
            chk("frame", FrameOut, vecs[v].frame);
            chk("count_popped", FifoCount, 0);
            repeat (3) tick();
            chk("done_ignored", Send, 1);
            begin_frame();
            ParityType = ~ParityType;
            DataLength = ~DataLength;
            StopBits   = ~StopBits;
            tick();
            chk("frame_held", FrameOut, vecs[v].frame);
            finish_frame(n);
            chk("drop_cycles", n, SYNC + 1);
            tick();
            chk("busy_idle", Busy, 0);
        end

        // Fill the FIFO against a stalled serializer.
        DataLength = 1'b1; ParityType = 2'b00; StopBits = 1'b0;
        DataValid = 1'b1; acc = 0; cyc = 0;
        while (acc < 5 && cyc < 12) begin
            DataIn = 8'h11 + 8'(acc);
            seen = DataReady;
            tick();
            cyc++;
            if (seen) acc++;
        end
        DataValid = 1'b0;
        chk("fill_accepts", acc, 5);
        chk("fill_cycles", cyc, 5);
        chk("fill_count", FifoCount, 4);
        chk("fill_ready", DataReady, 0);
        chk("fill_send", Send, 1);
        DataIn = 8'h99; DataValid = 1'b1;
        repeat (3) tick();
        DataValid = 1'b0;
        chk("full_no_push", FifoCount, 4);

        for (int k = 0; k < 5; k++) begin
            if (k != 0) begin
                tick();
                chk("gap_one_cycle", Send, 1);
                tick();
            end
            chk("b2b_frame", FrameOut, b2b_exp[k]);
            chk("b2b_count", FifoCount, (k == 0) ? 4 : 4 - k);
            begin_frame();
            if (k == 0) begin
                ParityType = 2'b10;
                StopBits   = 1'b1;
                tick();
                chk("b2b_frame_held", FrameOut, b2b_exp[0]);
            end
            finish_frame(n);
            chk("b2b_drop", n, SYNC + 1);
        end
        chk("last_gap_busy", Busy, 1);
        tick();
        chk("last_idle_busy", Busy, 0);
        chk("last_idle_send", Send, 0);

        // Reset in WAIT_DONE with three bytes buffered.
        push_byte(8'h21);
        push_byte(8'h22);
        push_byte(8'h23);
        push_byte(8'h24);
        chk("pre_rst_count", FifoCount, 3);
        begin_frame();
        chk("pre_rst_send", Send, 1);
        #2 ResetN = 1'b0;
        #1;
        chk("mid_rst_send", Send, 0);
        chk("mid_rst_count", FifoCount, 0);
        chk("mid_rst_frame", FrameOut, 12'hFFF);
        chk("mid_rst_busy", Busy, 0);
        TxActive = 1'b0; TxDone = 1'b1;
        tick();
        ResetN = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (Send) seen = 1'b1;
        end
        chk("post_rst_no_send", seen, 0);
        chk("post_rst_count", FifoCount, 0);
        chk("post_rst_busy", Busy, 0);

        push_byte(8'h5A);
        wait_send();
        tick();
        chk("post_rst_frame", FrameOut, 12'hCB4);
        begin_frame();
        finish_frame(n);
        chk("post_rst_drop", n, SYNC + 1);
        tick();
        chk("final_busy", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
